// File: rtl/xnor_hidden_roclk_pkg.sv
// bnnroclk_pkg: shared FSM state type and width helpers for the bnnroclk datapath.
package bnnroclk_pkg;
  typedef enum logic [1:0] {IDLE, HID, CLS, DONE} state_t;
  function automatic int sum_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xnor_hidden_roclk_popcount.sv
// popcount_xnor: combinational count of matching bit positions between a and b.
module popcount_xnor import bnnroclk_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic [sum_w(WIDTH)-1:0]    count
);
  localparam int CW = sum_w(WIDTH);
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(~(a[i] ^ b[i]));
  end
endmodule

// File: rtl/xnor_hidden_roclk.sv
// xnor_hidden_roclk: row-clocked XNOR-popcount hidden layer plus class sweep sequencer.
// Optional stall input enabled by defining XNOR_HIDDEN_ROCLK_STALL_EN.
module xnor_hidden_roclk import bnnroclk_pkg::*; #(
  parameter int FEAT_CNT   = 4,
  parameter int HIDDEN_CNT = 4,
  parameter int CLASS_CNT  = 4,
  parameter int THRESH     = (FEAT_CNT + 1) / 2,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] WEIGHTS = '0
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
  input  logic                           stall,
`endif
  input  logic [FEAT_CNT-1:0]            data,
  input  logic                           start,
  output logic                           busy,
  output logic [HIDDEN_CNT-1:0]          hidden,
  output logic                           enable_out,
  output logic [idx_w(HIDDEN_CNT)-1:0]   cnt_out,
  output logic                           clr_out,
  output logic                           done
);
  localparam int IW = idx_w(HIDDEN_CNT);
  localparam int SW = sum_w(FEAT_CNT);
  generate
    if (CLASS_CNT > HIDDEN_CNT || CLASS_CNT < 1) begin : g_bad_cfg
      $error("CLASS_CNT must be in 1..HIDDEN_CNT");
    end
  endgenerate
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [FEAT_CNT-1:0] x_reg, x_n;
  logic [HIDDEN_CNT-1:0] hidden_n;
  logic [SW-1:0] p;
  logic clr_q, hold, fire, last_h, last_c;
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif
  popcount_xnor #(.WIDTH(FEAT_CNT)) u_pop (
    .a(WEIGHTS[idx*FEAT_CNT +: FEAT_CNT]),
    .b(x_reg),
    .count(p)
  );
  assign fire   = 32'(p) >= 32'(THRESH);
  assign last_h = idx == IW'(HIDDEN_CNT - 1);
  assign last_c = idx == IW'(CLASS_CNT - 1);
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    x_n      = x_reg;
    hidden_n = hidden;
    case (state)
      IDLE: if (start) begin
        x_n      = data;
        hidden_n = '0;
        idx_n    = '0;
        state_n  = HID;
      end
      HID: if (!hold) begin
        hidden_n[idx] = fire;
        idx_n         = last_h ? '0 : idx + 1'b1;
        state_n       = last_h ? CLS : HID;
      end
      CLS: if (!hold) begin
        idx_n   = last_c ? '0 : idx + 1'b1;
        state_n = last_c ? DONE : CLS;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      x_reg  <= '0;
      hidden <= '0;
      clr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      x_reg  <= x_n;
      hidden <= hidden_n;
      clr_q  <= state == IDLE && start;
    end
  end
  assign busy       = state != IDLE;
  assign enable_out = state == CLS && !hold;
  assign cnt_out    = state == CLS ? idx : '0;
  assign clr_out    = clr_q;
  assign done       = state == DONE;
endmodule

// File: tb/tb_xnor_hidden_roclk.sv
// tb_xnor_hidden_roclk: directed self-checking bench for xnor_hidden_roclk.
module tb_xnor_hidden_roclk;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] data = '0;
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
  logic stall = 1'b0;
`endif
  logic busy, enable_out, clr_out, done;
  logic [3:0] hidden;
  logic [1:0] cnt_out;
  logic u1_busy, u1_enable, u1_clr, u1_done, u2_busy, u2_enable, u2_clr, u2_done;
  logic [3:0] u1_hidden, u2_hidden;
  logic [1:0] u1_cnt, u2_cnt;
  int checks = 0, errors = 0;

  localparam logic [15:0] W = 16'b0101_1010_0000_1111;

  always #5 clk = ~clk;

  xnor_hidden_roclk #(.FEAT_CNT(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .THRESH(2), .WEIGHTS(W)) u0 (
    .clk(clk), .rst(rst),
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
    .stall(stall),
`endif
    .data(data), .start(start), .busy(busy), .hidden(hidden), .enable_out(enable_out),
    .cnt_out(cnt_out), .clr_out(clr_out), .done(done));

  xnor_hidden_roclk #(.FEAT_CNT(4), .HIDDEN_CNT(4), .CLASS_CNT(1), .THRESH(0), .WEIGHTS(W)) u1 (
    .clk(clk), .rst(rst),
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
    .stall(stall),
`endif
    .data(data), .start(start), .busy(u1_busy), .hidden(u1_hidden), .enable_out(u1_enable),
    .cnt_out(u1_cnt), .clr_out(u1_clr), .done(u1_done));

  xnor_hidden_roclk #(.FEAT_CNT(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .THRESH(5), .WEIGHTS(W)) u2 (
    .clk(clk), .rst(rst),
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
    .stall(stall),
`endif
    .data(data), .start(start), .busy(u2_busy), .hidden(u2_hidden), .enable_out(u2_enable),
    .cnt_out(u2_cnt), .clr_out(u2_clr), .done(u2_done));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one inference and observes it up to and including its DONE cycle.
  task automatic run(input logic [3:0] d, output logic [3:0] hid, output int en_n,
                     output int done_at, output bit seq_ok, output bit clr1);
    data = d;
    start = 1'b1;
    step();
    start = 1'b0;
    clr1 = clr_out && busy;
    done_at = -1;
    en_n = 0;
    seq_ok = 1'b1;
    hid = 'x;
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      if (enable_out) begin
        if (en_n == 0) hid = hidden;
        if (cnt_out !== en_n[1:0] || hidden !== hid) seq_ok = 1'b0;
        en_n++;
      end else if (cnt_out !== 2'd0) seq_ok = 1'b0;
      if (done) done_at = c;
      else step();
    end
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({busy, hidden, enable_out, cnt_out, clr_out, done} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {busy, hidden, enable_out, cnt_out, clr_out, done});
    end
  endtask

  task automatic test_basic();
    logic [3:0] hid; int en_n, done_at; bit seq_ok, clr1;
    run(4'b1110, hid, en_n, done_at, seq_ok, clr1);
    checks++; if (hid !== 4'b0101) begin errors++; $display("FAIL basic_hidden got %b want 0101", hid); end
    checks++; if (en_n != 3) begin errors++; $display("FAIL basic_enable_cycles got %0d want 3", en_n); end
    checks++; if (done_at != 8) begin errors++; $display("FAIL basic_done_cycle got %0d want 8", done_at); end
    checks++; if (!seq_ok) begin errors++; $display("FAIL basic_cnt_sequence got bad want 0,1,2 stable"); end
    checks++; if (!clr1) begin errors++; $display("FAIL basic_clr_pulse got 0 want 1"); end
  endtask

  task automatic test_patterns();
    logic [3:0] hid; int en_n, done_at; bit seq_ok, clr1;
    run(4'b1100, hid, en_n, done_at, seq_ok, clr1);
    checks++; if (hid !== 4'b1111 || done_at != 8) begin errors++; $display("FAIL pat1100 got %b/%0d want 1111/8", hid, done_at); end
    checks++; if (hidden !== 4'b1111 || busy !== 1'b0) begin errors++; $display("FAIL pat1100_hold got %b busy %b want 1111 busy 0", hidden, busy); end
    run(4'b0001, hid, en_n, done_at, seq_ok, clr1);
    checks++; if (hid !== 4'b1010 || done_at != 8) begin errors++; $display("FAIL pat0001 got %b/%0d want 1010/8", hid, done_at); end
    checks++; if (!seq_ok || en_n != 3) begin errors++; $display("FAIL pat0001_seq got %0d enables want 3", en_n); end
  endtask

  task automatic test_start_busy();
    int dn = 0;
    data = 4'b1110;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    data = 4'b1100;
    start = 1'b1;
    step();
    start = 1'b0;
    data = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      if (done) dn++;
      step();
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", dn); end
    checks++; if (hidden !== 4'b0101) begin errors++; $display("FAIL busy_start_hidden got %b want 0101", hidden); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] hid; int en_n, done_at, dn = 0; bit seq_ok, clr1, found = 1'b0;
    data = 4'b1110;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (enable_out && cnt_out == 2'd1) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach got none want cnt_out=1"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, hidden, enable_out, cnt_out, clr_out, done} !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b want 0", {busy, hidden, enable_out, cnt_out, clr_out, done});
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) dn++;
      step();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active want 0", dn); end
    run(4'b1100, hid, en_n, done_at, seq_ok, clr1);
    checks++; if (hid !== 4'b1111 || done_at != 8) begin errors++; $display("FAIL rst_mid_rerun got %b/%0d want 1111/8", hid, done_at); end
    checks++; if (!seq_ok || en_n != 3 || !clr1) begin errors++; $display("FAIL rst_mid_rerun_seq got %0d enables want 3", en_n); end
  endtask

  task automatic test_back_to_back();
    int clr_n = 0, done_n = 0, low_n = 0;
    bit low_ok = 1'b1;
    data = 4'b1110;
    start = 1'b1;
    step();
    for (int c = 1; c <= 26; c++) begin
      if (clr_out) clr_n++;
      if (done) done_n++;
      if (!busy) begin
        low_n++;
        if (c != 9 && c != 18) low_ok = 1'b0;
      end
      if (c < 26) step();
    end
    start = 1'b0;
    step();
    step();
    step();
    checks++; if (clr_n != 3) begin errors++; $display("FAIL b2b_clr_count got %0d want 3", clr_n); end
    checks++; if (done_n != 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", done_n); end
    checks++; if (low_n != 2 || !low_ok) begin errors++; $display("FAIL b2b_idle_gap got %0d low want 2 at 9,18", low_n); end
    checks++; if (busy !== 1'b0 || hidden !== 4'b0101) begin errors++; $display("FAIL b2b_final got busy %b hidden %b want 0/0101", busy, hidden); end
  endtask

  task automatic test_boundary();
    int u1_en = 0, u1_da = -1, u2_da = -1;
    bit cnt_ok = 1'b1;
    data = 4'b0110;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (u1_enable) begin
        u1_en++;
        if (u1_cnt !== 2'd0) cnt_ok = 1'b0;
      end
      if (u1_done) u1_da = c;
      if (u2_done) u2_da = c;
      step();
    end
    checks++; if (u1_hidden !== 4'b1111) begin errors++; $display("FAIL thresh0_hidden got %b want 1111", u1_hidden); end
    checks++; if (u1_en != 1 || !cnt_ok) begin errors++; $display("FAIL class1_enable got %0d want 1 at cnt 0", u1_en); end
    checks++; if (u1_da != 6) begin errors++; $display("FAIL class1_done got %0d want 6", u1_da); end
    checks++; if (u2_hidden !== 4'b0000) begin errors++; $display("FAIL thresh5_hidden got %b want 0000", u2_hidden); end
    checks++; if (u2_da != 8) begin errors++; $display("FAIL thresh5_done got %0d want 8", u2_da); end
  endtask

`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
  task automatic test_stall();
    int c = 1, done_at = -1;
    data = 4'b1110;
    start = 1'b1;
    step();
    start = 1'b0;
    while (c < 20 && !(enable_out && cnt_out == 2'd1)) begin
      step();
      c++;
    end
    checks++; if (c != 6) begin errors++; $display("FAIL stall_reach got %0d want 6", c); end
    stall = 1'b1;
    #1;
    checks++; if (enable_out !== 1'b0 || cnt_out !== 2'd1) begin errors++; $display("FAIL stall_c6 got en %b cnt %0d want 0/1", enable_out, cnt_out); end
    step();
    c++;
    checks++; if (enable_out !== 1'b0 || cnt_out !== 2'd1) begin errors++; $display("FAIL stall_c7 got en %b cnt %0d want 0/1", enable_out, cnt_out); end
    step();
    c++;
    stall = 1'b0;
    #1;
    checks++; if (enable_out !== 1'b1 || cnt_out !== 2'd1) begin errors++; $display("FAIL stall_resume got en %b cnt %0d want 1/1", enable_out, cnt_out); end
    while (c < 30 && done_at < 0) begin
      if (done) done_at = c;
      else begin
        step();
        c++;
      end
    end
    step();
    checks++; if (done_at != 10) begin errors++; $display("FAIL stall_done got %0d want 10", done_at); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_boundary();
`ifdef XNOR_HIDDEN_ROCLK_STALL_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
